uart_boot_loader: RTL and testbench

- Sequences program load from the UART receiver into instruction memory before the CPU core runs.
- Parses a length-prefixed byte stream and assembles little-endian 32-bit words.
- Writes each word to sequential instruction-memory addresses starting at 0, then checks a trailing XOR checksum.
- Holds the core stalled until the load completes successfully, then reports done or error.

---
 rtl/uart_boot_loader_if.sv | 22 ++
 rtl/uart_boot_loader.sv | 125 ++++++++++++
 tb/tb_uart_boot_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// UART-RX byte strobes in, instruction-memory word writes out.
// One bundle shared by the boot loader and whatever drives/observes it.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output rx_data, rx_valid, rx_err,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid, rx_err,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and keeps the core stalled until the image is verified.
module uart_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_boot_loader_if.slave bus,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {HDR, PAY, CHK, DONE, ERR} state_t;

    localparam logic [ADDR_W:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   W_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              stall_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       word_w;
    logic              live_w;
    logic              hdr_bad_w;
    logic [ADDR_W:0]   words_inc_w;

    // The three lower bytes sit in asm_q; the 4th arrives on rx_data.
    assign word_w      = {bus.rx_data, asm_q};
    assign live_w      = (state_q == HDR) || (state_q == PAY) ||
                         (state_q == CHK);
    assign hdr_bad_w   = (|word_w[31:ADDR_W+1]) ||
                         (word_w[ADDR_W:0] > CAP);
    assign words_inc_w = words_q + W_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HDR;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            xor_q   <= '0;
            n_q     <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            stall_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            // Hold on the last address so a full-capacity load never wraps.
            if (we_q && (words_q != n_q)) begin
                addr_q <= addr_q + A_ONE;
            end
            if (live_w && bus.rx_err) begin
                state_q <= ERR;
                err_q   <= 1'b1;
            end else if (live_w && bus.rx_valid) begin
                unique case (state_q)
                    HDR: begin
                        asm_q <= {bus.rx_data, asm_q[23:8]};
                        xor_q <= xor_q ^ bus.rx_data;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            n_q <= word_w[ADDR_W:0];
                            if (hdr_bad_w) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else if (word_w == 32'd0) begin
                                state_q <= CHK;
                            end else begin
                                state_q <= PAY;
                            end
                        end
                    end
                    PAY: begin
                        asm_q <= {bus.rx_data, asm_q[23:8]};
                        xor_q <= xor_q ^ bus.rx_data;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= word_w;
                            words_q <= words_inc_w;
                            if (words_inc_w == n_q) begin
                                state_q <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        if (bus.rx_data == xor_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            stall_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_stall     = stall_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Drives one byte stream into two loaders (ADDR_W=10 and ADDR_W=4) and
// checks both against a stream-position model every cycle.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  r_data = '0;
    logic        r_valid = 1'b0;
    logic        r_err = 1'b0;

    logic        o0_stall, o0_done, o0_err;
    logic [10:0] o0_wl;
    logic        o1_stall, o1_done, o1_err;
    logic [4:0]  o1_wl;

    int nchk = 0;
    int nerr = 0;

    uart_boot_loader_if #(.ADDR_W(10)) b0 ();
    uart_boot_loader_if #(.ADDR_W(4))  b1 ();

    assign b0.rx_data  = r_data;
    assign b0.rx_valid = r_valid;
    assign b0.rx_err   = r_err;
    assign b1.rx_data  = r_data;
    assign b1.rx_valid = r_valid;
    assign b1.rx_err   = r_err;

    uart_boot_loader #(.ADDR_W(10)) d0 (
        .clk(clk), .reset_n(rst_n), .bus(b0.slave),
        .cpu_stall(o0_stall), .load_done(o0_done),
        .load_error(o0_err), .words_loaded(o0_wl)
    );

    uart_boot_loader #(.ADDR_W(4)) d1 (
        .clk(clk), .reset_n(rst_n), .bus(b1.slave),
        .cpu_stall(o1_stall), .load_done(o1_done),
        .load_error(o1_err), .words_loaded(o1_wl)
    );

    always #5 clk = ~clk;

    // Model: position in the stream decides what each byte means.
    longint      m_cnt[2], m_n[2];
    logic [7:0]  m_x[2];
    logic [31:0] m_word[2], m_wdata[2];
    int          m_wl[2], m_addr[2];
    bit          m_we[2], m_done[2], m_err[2];

    logic [31:0] l0a[$], l0d[$], l1a[$], l1d[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_n[i] = 0; m_x[i] = 0; m_word[i] = 0;
            m_wdata[i] = 0; m_wl[i] = 0; m_addr[i] = 0;
            m_we[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
    endfunction

    function automatic void model_step();
        longint cap;
        for (int i = 0; i < 2; i++) begin
            cap = (i == 0) ? 1024 : 16;
            m_we[i] = 0;
            if (!m_done[i] && !m_err[i]) begin
                if (r_err) begin
                    m_err[i] = 1;
                end else if (r_valid) begin
                    if (m_cnt[i] < 4) begin
                        m_n[i] |= longint'(r_data) << (8 * m_cnt[i]);
                        m_x[i] ^= r_data;
                        m_cnt[i]++;
                        if (m_cnt[i] == 4 && m_n[i] > cap) m_err[i] = 1;
                    end else if (m_cnt[i] < 4 + 4 * m_n[i]) begin
                        m_word[i] |= {24'h0, r_data} << (8 * ((m_cnt[i] - 4) % 4));
                        m_x[i] ^= r_data;
                        m_cnt[i]++;
                        if ((m_cnt[i] - 4) % 4 == 0) begin
                            m_we[i] = 1;
                            m_wdata[i] = m_word[i];
                            m_word[i] = 0;
                            m_wl[i]++;
                        end
                    end else begin
                        if (r_data == m_x[i]) m_done[i] = 1;
                        else m_err[i] = 1;
                    end
                end
            end
            if (m_we[i]) m_addr[i] = m_wl[i] - 1;
            else if (m_wl[i] == 0) m_addr[i] = 0;
            else if (m_wl[i] < m_n[i]) m_addr[i] = m_wl[i];
            else m_addr[i] = m_wl[i] - 1;
        end
    endfunction

    initial forever begin
        @(negedge clk);
        chk("we0",    32'(b0.mem_we),    32'(m_we[0]));
        chk("addr0",  32'(b0.mem_addr),  32'(m_addr[0]));
        chk("wdata0", b0.mem_wdata,      m_wdata[0]);
        chk("wl0",    32'(o0_wl),        32'(m_wl[0]));
        chk("done0",  32'(o0_done),      32'(m_done[0]));
        chk("err0",   32'(o0_err),       32'(m_err[0]));
        chk("stall0", 32'(o0_stall),     32'(!m_done[0]));
        chk("we1",    32'(b1.mem_we),    32'(m_we[1]));
        chk("addr1",  32'(b1.mem_addr),  32'(m_addr[1]));
        chk("wdata1", b1.mem_wdata,      m_wdata[1]);
        chk("wl1",    32'(o1_wl),        32'(m_wl[1]));
        chk("done1",  32'(o1_done),      32'(m_done[1]));
        chk("err1",   32'(o1_err),       32'(m_err[1]));
        chk("stall1", 32'(o1_stall),     32'(!m_done[1]));
        if (b0.mem_we) begin
            l0a.push_back(32'(b0.mem_addr));
            l0d.push_back(b0.mem_wdata);
        end
        if (b1.mem_we) begin
            l1a.push_back(32'(b1.mem_addr));
            l1d.push_back(b1.mem_wdata);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit e);
        r_valid = v;
        r_data  = d;
        r_err   = e;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        r_valid = 1'b0;
        r_err   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) cyc(1'b0, 8'($urandom), 1'b0);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic do_reset();
        r_valid = 1'b0;
        r_err   = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        l0a = {}; l0d = {}; l1a = {}; l1d = {};
    endtask

    task automatic send_stream(input int n, input int maxgap,
                               input int chk_ovr, input int err_at,
                               input int rst_at);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [31:0] w;
        q = {};
        q.push_back(n[7:0]);   q.push_back(n[15:8]);
        q.push_back(n[23:16]); q.push_back(n[31:24]);
        for (int i = 0; i < n; i++) begin
            w = (i < wq.size()) ? wq[i] : $urandom;
            q.push_back(w[7:0]);   q.push_back(w[15:8]);
            q.push_back(w[23:16]); q.push_back(w[31:24]);
        end
        x = 8'h00;
        foreach (q[k]) x ^= q[k];
        q.push_back(chk_ovr >= 0 ? chk_ovr[7:0] : x);
        foreach (q[k]) begin
            if (k == rst_at) do_reset();
            if (k == err_at) cyc(1'($urandom_range(0, 1)), q[k], 1'b1);
            send_byte(q[k], $urandom_range(0, maxgap));
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pin_reset(input string tag);
        chk({tag, "_stall"}, 32'(o0_stall), 32'd1);
        chk({tag, "_done"},  32'(o0_done),  32'd0);
        chk({tag, "_err"},   32'(o0_err),   32'd0);
        chk({tag, "_wl"},    32'(o0_wl),    32'd0);
        chk({tag, "_addr"},  32'(b0.mem_addr), 32'd0);
        chk({tag, "_wdata"}, b0.mem_wdata,  32'd0);
        chk({tag, "_we"},    32'(b0.mem_we), 32'd0);
    endtask

    task automatic pin_s1(input string tag);
        chk({tag, "_done"},  32'(o0_done),  32'd1);
        chk({tag, "_stall"}, 32'(o0_stall), 32'd0);
        chk({tag, "_wl"},    32'(o0_wl),    32'd2);
        chk({tag, "_nwr"},   32'(l0a.size()), 32'd2);
        if (l0a.size() >= 2) begin
            chk({tag, "_a0"}, l0a[0], 32'd0);
            chk({tag, "_d0"}, l0d[0], 32'h00100513);
            chk({tag, "_a1"}, l0a[1], 32'd1);
            chk({tag, "_d1"}, l0d[1], 32'h00200593);
        end
    endtask

    initial begin
        int n, mode, tot;
        model_reset();
        do_reset();
        pin_reset("rst");

        wq = {32'h00100513, 32'h00200593};
        send_stream(2, 2, -1, -1, -1);
        pin_s1("s1");

        do_reset();
        send_stream(2, 0, -1, -1, -1);
        pin_s1("b2b");

        do_reset();
        send_stream(2, 1, 'h83, -1, -1);
        chk("bad_err",   32'(o0_err),   32'd1);
        chk("bad_done",  32'(o0_done),  32'd0);
        chk("bad_stall", 32'(o0_stall), 32'd1);
        chk("bad_nwr",   32'(l0a.size()), 32'd2);

        do_reset();
        send_stream(0, 1, -1, -1, -1);
        chk("n0_done", 32'(o0_done), 32'd1);
        chk("n0_nwr",  32'(l0a.size()), 32'd0);

        do_reset();
        send_byte(8'h11, 0); send_byte(8'h00, 1);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("cap_err1", 32'(o1_err), 32'd1);
        chk("cap_ok0",  32'(o0_err), 32'd0);
        repeat (8) send_byte(8'($urandom), 0);
        chk("cap_nwr1", 32'(l1a.size()), 32'd0);

        do_reset();
        wq = {};
        send_stream(16, 1, -1, -1, -1);
        chk("full_done1", 32'(o1_done), 32'd1);
        chk("full_wl1",   32'(o1_wl),   32'd16);
        chk("full_nwr1",  32'(l1a.size()), 32'd16);
        if (l1a.size() == 16) chk("full_last1", l1a[15], 32'd15);

        do_reset();
        wq = {32'h00100513, 32'h00200593};
        send_stream(2, 1, -1, 5, -1);
        chk("rxe_err", 32'(o0_err), 32'd1);
        chk("rxe_nwr", 32'(l0a.size()), 32'd0);

        do_reset();
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 1);
        send_byte(8'h10, 0); send_byte(8'h00, 0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        do_reset();
        pin_reset("mid");
        wq = {32'hDEADBEEF};
        send_stream(1, 1, -1, -1, -1);
        chk("mid_nwr",  32'(l0a.size()), 32'd1);
        if (l0a.size() == 1) begin
            chk("mid_a", l0a[0], 32'd0);
            chk("mid_d", l0d[0], 32'hDEADBEEF);
        end
        chk("mid_done", 32'(o0_done), 32'd1);

        wq = {};
        for (int t = 0; t < 30; t++) begin
            do_reset();
            n    = $urandom_range(0, 20);
            mode = $urandom_range(0, 9);
            tot  = 5 + 4 * n;
            if (mode == 7)
                send_stream(n, 2, $urandom_range(0, 255), -1, -1);
            else if (mode == 8)
                send_stream(n, 2, -1, $urandom_range(0, tot - 1), -1);
            else if (mode == 9)
                send_stream(n, 2, -1, -1, $urandom_range(1, tot - 1));
            else
                send_stream(n, $urandom_range(0, 3), -1, -1, -1);
        end

        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
